// File: rtl/conv_transpose2d_engine.sv
// conv_transpose2d_engine
// Sequential 2-D transposed convolution: latches a flat CHW feature map, its
// ConvTranspose2d-layout weights and a per-channel bias, then scatters one
// multiply-accumulate per clock into an internal output buffer. The result is
// presented on output_tensor_flat together with a one-cycle done pulse.
// Optional build macro: CONVT_RELU_EN clamps negative results to zero on
// output while leaving the accumulators untouched.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | wait for start, latch inputs when it arrives
// INIT     | preload accumulators with bias, clear loop counters
// SCATTER  | one MAC per cycle over ic, ih, iw, oc, kh, kw
// DONE     | publish accumulators, pulse done, drop busy

module conv_transpose2d_engine #(
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 2,
  parameter int IN_HEIGHT    = 2,
  parameter int IN_WIDTH     = 2,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 2,
  parameter int PADDING      = 0,
  parameter int DATA_WIDTH   = 32,
  localparam int OUT_HEIGHT  = (IN_HEIGHT - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE,
  localparam int OUT_WIDTH   = (IN_WIDTH - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic                                                         start,
  input  logic [IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0]          input_tensor_flat,
  input  logic [IN_CHANNELS*OUT_CHANNELS*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weights_flat,
  input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                            bias_flat,
  output logic                                                         busy,
  output logic                                                         done,
  output logic [OUT_CHANNELS*OUT_HEIGHT*OUT_WIDTH*DATA_WIDTH-1:0]       output_tensor_flat
);

  localparam int IN_ELEMS  = IN_CHANNELS * IN_HEIGHT * IN_WIDTH;
  localparam int W_ELEMS   = IN_CHANNELS * OUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE;
  localparam int PLANE     = OUT_HEIGHT * OUT_WIDTH;
  localparam int OUT_ELEMS = OUT_CHANNELS * PLANE;

  localparam int IN_AW  = (IN_ELEMS  > 1) ? $clog2(IN_ELEMS)  : 1;
  localparam int W_AW   = (W_ELEMS   > 1) ? $clog2(W_ELEMS)   : 1;
  localparam int OUT_AW = (OUT_ELEMS > 1) ? $clog2(OUT_ELEMS) : 1;
  localparam int B_AW   = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;

  localparam logic [15:0] IC_LAST = 16'(IN_CHANNELS - 1);
  localparam logic [15:0] IH_LAST = 16'(IN_HEIGHT - 1);
  localparam logic [15:0] IW_LAST = 16'(IN_WIDTH - 1);
  localparam logic [15:0] OC_LAST = 16'(OUT_CHANNELS - 1);
  localparam logic [15:0] K_LAST  = 16'(KERNEL_SIZE - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_INIT    = 2'd1;
  localparam logic [1:0] ST_SCATTER = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0] state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [15:0] ic_q, ih_q, iw_q, oc_q, kh_q, kw_q;
  logic [15:0] ic_d, ih_d, iw_d, oc_d, kh_d, kw_d;

  logic [DATA_WIDTH-1:0] in_q  [IN_ELEMS];
  logic [DATA_WIDTH-1:0] w_q   [W_ELEMS];
  logic [DATA_WIDTH-1:0] b_q   [OUT_CHANNELS];
  logic [DATA_WIDTH-1:0] acc_q [OUT_ELEMS];
  logic [OUT_ELEMS*DATA_WIDTH-1:0] out_q;

  int                      oh_s, ow_s;
  int                      in_idx_s, w_idx_s, acc_idx_s;
  logic                    in_range;
  logic [IN_AW-1:0]        in_idx;
  logic [W_AW-1:0]         w_idx;
  logic [OUT_AW-1:0]       acc_idx;
  logic signed [DATA_WIDTH-1:0] a_s, w_s, prod_s;
  logic [DATA_WIDTH-1:0]   mac_sum;

  assign busy               = busy_q;
  assign done               = done_q;
  assign output_tensor_flat = out_q;

  // Address generation and the single multiply-accumulate for the current tuple.
  always_comb begin
    oh_s      = int'(ih_q) * STRIDE + int'(kh_q) - PADDING;
    ow_s      = int'(iw_q) * STRIDE + int'(kw_q) - PADDING;
    in_range  = (oh_s >= 0) && (oh_s < OUT_HEIGHT) && (ow_s >= 0) && (ow_s < OUT_WIDTH);
    in_idx_s  = int'(ic_q) * IN_HEIGHT * IN_WIDTH + int'(ih_q) * IN_WIDTH + int'(iw_q);
    w_idx_s   = ((int'(ic_q) * OUT_CHANNELS + int'(oc_q)) * KERNEL_SIZE + int'(kh_q)) * KERNEL_SIZE
                + int'(kw_q);
    acc_idx_s = int'(oc_q) * PLANE + oh_s * OUT_WIDTH + ow_s;
    in_idx    = IN_AW'(in_idx_s);
    w_idx     = W_AW'(w_idx_s);
    acc_idx   = OUT_AW'(acc_idx_s);
    a_s       = $signed(in_q[in_idx]);
    w_s       = $signed(w_q[w_idx]);
    prod_s    = a_s * w_s;
    mac_sum   = acc_q[acc_idx] + $unsigned(prod_s);
  end

  // Next-state logic: FSM transitions and the nested loop counter carry chain.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ic_d = ic_q;
    ih_d = ih_q;
    iw_d = iw_q;
    oc_d = oc_q;
    kh_d = kh_q;
    kw_d = kw_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_INIT;
          busy_d  = 1'b1;
        end
      end
      ST_INIT: begin
        ic_d = '0;
        ih_d = '0;
        iw_d = '0;
        oc_d = '0;
        kh_d = '0;
        kw_d = '0;
        state_d = ST_SCATTER;
      end
      ST_SCATTER: begin
        if (kw_q != K_LAST) kw_d = kw_q + 16'd1;
        else begin
          kw_d = '0;
          if (kh_q != K_LAST) kh_d = kh_q + 16'd1;
          else begin
            kh_d = '0;
            if (oc_q != OC_LAST) oc_d = oc_q + 16'd1;
            else begin
              oc_d = '0;
              if (iw_q != IW_LAST) iw_d = iw_q + 16'd1;
              else begin
                iw_d = '0;
                if (ih_q != IH_LAST) ih_d = ih_q + 16'd1;
                else begin
                  ih_d = '0;
                  if (ic_q != IC_LAST) ic_d = ic_q + 16'd1;
                  else begin
                    ic_d    = '0;
                    state_d = ST_DONE;
                  end
                end
              end
            end
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers and loop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ic_q <= '0;
      ih_q <= '0;
      iw_q <= '0;
      oc_q <= '0;
      kh_q <= '0;
      kw_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ic_q <= ic_d;
      ih_q <= ih_d;
      iw_q <= iw_d;
      oc_q <= oc_d;
      kh_q <= kh_d;
      kw_q <= kw_d;
    end
  end

  // Operand capture, accumulator buffer and published output tensor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IN_ELEMS; i++) in_q[i] <= '0;
      for (int i = 0; i < W_ELEMS; i++) w_q[i] <= '0;
      for (int i = 0; i < OUT_CHANNELS; i++) b_q[i] <= '0;
      for (int i = 0; i < OUT_ELEMS; i++) acc_q[i] <= '0;
      out_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < IN_ELEMS; i++) in_q[i] <= input_tensor_flat[i*DATA_WIDTH +: DATA_WIDTH];
            for (int i = 0; i < W_ELEMS; i++) w_q[i] <= weights_flat[i*DATA_WIDTH +: DATA_WIDTH];
            for (int i = 0; i < OUT_CHANNELS; i++) b_q[i] <= bias_flat[i*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        ST_INIT: begin
          for (int oc = 0; oc < OUT_CHANNELS; oc++)
            for (int p = 0; p < PLANE; p++)
              acc_q[oc*PLANE + p] <= b_q[B_AW'(oc)];
        end
        ST_SCATTER: begin
          // Out-of-range taps still burn their cycle so latency never depends on geometry.
          if (in_range) acc_q[acc_idx] <= mac_sum;
        end
        ST_DONE: begin
          for (int e = 0; e < OUT_ELEMS; e++) begin
`ifdef CONVT_RELU_EN
            out_q[e*DATA_WIDTH +: DATA_WIDTH] <= acc_q[e][DATA_WIDTH-1] ? '0 : acc_q[e];
`else
            out_q[e*DATA_WIDTH +: DATA_WIDTH] <= acc_q[e];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_transpose2d_engine.sv
// Self-checking bench for conv_transpose2d_engine. Four instances cover the
// default geometry, overlapping taps (stride 1), cropped output (padding 1)
// and a 1x1 case for sign/wrap arithmetic. Expected tensors come from a
// direct reference model pushed into a scoreboard queue at launch time.

module tb_conv_transpose2d_engine;

  // instance 0: defaults
  localparam int D_IC = 1, D_OC = 2, D_IH = 2, D_IW = 2, D_K = 2, D_S = 2, D_P = 0;
  localparam int D_OH = (D_IH-1)*D_S - 2*D_P + D_K;
  // instance 1: overlap
  localparam int V_OH = 3;
  // instance 2: crop
  localparam int C_OH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] start_v = '0;
  logic [3:0] busy_v, done_v;

  logic [4*32-1:0]   in0;  logic [8*32-1:0] w0;  logic [2*32-1:0] b0;  logic [32*32-1:0] out0;
  logic [4*32-1:0]   in1;  logic [4*32-1:0] w1;  logic [31:0]     b1;  logic [9*32-1:0]  out1;
  logic [4*32-1:0]   in2;  logic [9*32-1:0] w2;  logic [31:0]     b2;  logic [4*32-1:0]  out2;
  logic [31:0]       in3;  logic [31:0]     w3;  logic [31:0]     b3;  logic [31:0]      out3;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int ia[];
  int wa[];
  int ba[];

  always #5 clk = ~clk;

  conv_transpose2d_engine u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .input_tensor_flat(in0), .weights_flat(w0),
    .bias_flat(b0), .busy(busy_v[0]), .done(done_v[0]), .output_tensor_flat(out0));

  conv_transpose2d_engine #(.OUT_CHANNELS(1), .STRIDE(1)) u_ovl (
    .clk(clk), .rst(rst), .start(start_v[1]), .input_tensor_flat(in1), .weights_flat(w1),
    .bias_flat(b1), .busy(busy_v[1]), .done(done_v[1]), .output_tensor_flat(out1));

  conv_transpose2d_engine #(.OUT_CHANNELS(1), .STRIDE(1), .KERNEL_SIZE(3), .PADDING(1)) u_crop (
    .clk(clk), .rst(rst), .start(start_v[2]), .input_tensor_flat(in2), .weights_flat(w2),
    .bias_flat(b2), .busy(busy_v[2]), .done(done_v[2]), .output_tensor_flat(out2));

  conv_transpose2d_engine #(.IN_CHANNELS(1), .OUT_CHANNELS(1), .IN_HEIGHT(1), .IN_WIDTH(1),
                            .KERNEL_SIZE(1), .STRIDE(1)) u_sgn (
    .clk(clk), .rst(rst), .start(start_v[3]), .input_tensor_flat(in3), .weights_flat(w3),
    .bias_flat(b3), .busy(busy_v[3]), .done(done_v[3]), .output_tensor_flat(out3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_out(input int inst, input int e);
    case (inst)
      0: return out0[e*32 +: 32];
      1: return out1[e*32 +: 32];
      2: return out2[e*32 +: 32];
      default: return out3[e*32 +: 32];
    endcase
  endfunction

  function automatic int n_out(input int inst);
    case (inst)
      0: return D_OC * D_OH * D_OH;
      1: return V_OH * V_OH;
      2: return C_OH * C_OH;
      default: return 1;
    endcase
  endfunction

  // Pack the int stimulus arrays onto the selected instance's buses.
  task automatic drive(input int inst);
    case (inst)
      0: begin
        foreach (ia[i]) in0[i*32 +: 32] = ia[i];
        foreach (wa[i]) w0[i*32 +: 32]  = wa[i];
        foreach (ba[i]) b0[i*32 +: 32]  = ba[i];
      end
      1: begin
        foreach (ia[i]) in1[i*32 +: 32] = ia[i];
        foreach (wa[i]) w1[i*32 +: 32]  = wa[i];
        b1 = ba[0];
      end
      2: begin
        foreach (ia[i]) in2[i*32 +: 32] = ia[i];
        foreach (wa[i]) w2[i*32 +: 32]  = wa[i];
        b2 = ba[0];
      end
      default: begin
        in3 = ia[0];
        w3  = wa[0];
        b3  = ba[0];
      end
    endcase
  endtask

  // Reference transposed convolution; int arithmetic wraps at 32 bits.
  task automatic model(input int nic, input int noc, input int nih, input int niw,
                       input int k, input int s, input int p);
    int oh_n, ow_n, oh, ow, v;
    int acc[];
    oh_n = (nih-1)*s - 2*p + k;
    ow_n = (niw-1)*s - 2*p + k;
    acc = new[noc*oh_n*ow_n];
    for (int oc = 0; oc < noc; oc++)
      for (int e = 0; e < oh_n*ow_n; e++) acc[oc*oh_n*ow_n + e] = ba[oc];
    for (int ic = 0; ic < nic; ic++)
      for (int ih = 0; ih < nih; ih++)
        for (int iw = 0; iw < niw; iw++)
          for (int oc = 0; oc < noc; oc++)
            for (int kh = 0; kh < k; kh++)
              for (int kw = 0; kw < k; kw++) begin
                oh = ih*s + kh - p;
                ow = iw*s + kw - p;
                if (oh >= 0 && oh < oh_n && ow >= 0 && ow < ow_n)
                  acc[(oc*oh_n + oh)*ow_n + ow] += ia[(ic*nih + ih)*niw + iw] *
                                                   wa[((ic*noc + oc)*k + kh)*k + kw];
              end
    foreach (acc[e]) begin
      v = acc[e];
`ifdef CONVT_RELU_EN
      if (v < 0) v = 0;
`endif
      exp_q.push_back(v);
    end
  endtask

  // Launch one operation, check timing/handshake, then drain the scoreboard.
  task automatic run_op(input int inst, input int exp_edges, input int pulse_at,
                        input bit change_in, input int extra, input string tag);
    int edges;
    int dones;
    bit seen;
    edges = 0;
    seen  = 1'b0;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy_v[inst]), 32'd1);
    while (!seen && edges < 500) begin
      @(posedge clk); #1;
      edges++;
      if (edges == pulse_at) start_v[inst] = 1'b1;
      if (edges == pulse_at + 1) start_v[inst] = 1'b0;
      if (change_in && edges == 3) in0 = ~in0;
      if (done_v[inst]) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, edges, exp_edges);
    chk({tag, "_busy_fall"}, 32'(busy_v[inst]), 32'd0);
    for (int e = 0; e < n_out(inst); e++) begin
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      else chk({tag, "_out"}, get_out(inst, e), exp_q.pop_front());
    end
    @(posedge clk); #1;
    chk({tag, "_done_pulse_width"}, 32'(done_v[inst]), 32'd0);
    dones = 0;
    for (int c = 0; c < extra; c++) begin
      @(posedge clk); #1;
      if (done_v[inst]) dones++;
    end
    if (extra > 0) chk({tag, "_extra_done"}, dones, 0);
  endtask

  initial begin
    in0 = '0; w0 = '0; b0 = '0;
    in1 = '0; w1 = '0; b1 = '0;
    in2 = '0; w2 = '0; b2 = '0;
    in3 = '0; w3 = '0; b3 = '0;

    // reset state
    #12;
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_done", 32'(done_v[0]), 32'd0);
    chk("rst_out_nonzero", 32'(out0 != '0), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // defaults, non-overlapping blocks
    ia = '{1, 2, 3, 4};
    wa = '{1, 1, 1, 1, 2, 2, 2, 2};
    ba = '{10, -1};
    drive(0);
    model(D_IC, D_OC, D_IH, D_IW, D_K, D_S, D_P);
    run_op(0, 34, 0, 1'b0, 0, "dflt");
    chk("dflt_oc0_tl", get_out(0, 0), 32'd11);
    chk("dflt_oc0_br", get_out(0, 15), 32'd14);
    chk("dflt_oc1_tl", get_out(0, 16), 32'd1);
    chk("dflt_oc1_br", get_out(0, 31), 32'd7);

    // abort mid-scatter with reset, then a fresh run
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_done", 32'(done_v[0]), 32'd0);
    chk("abort_out_nonzero", 32'(out0 != '0), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    model(D_IC, D_OC, D_IH, D_IW, D_K, D_S, D_P);
    run_op(0, 34, 0, 1'b0, 0, "post_abort");

    // start while busy is ignored; input changes after launch do not leak in
    ia = '{5, -6, 7, 100};
    wa = '{3, -1, 2, 4, -2, 1, 0, 9};
    ba = '{-20, 33};
    drive(0);
    model(D_IC, D_OC, D_IH, D_IW, D_K, D_S, D_P);
    run_op(0, 34, 5, 1'b1, 40, "hshk");

    // overlapping taps
    ia = '{1, 1, 1, 1};
    wa = '{1, 1, 1, 1};
    ba = '{0};
    drive(1);
    model(1, 1, 2, 2, 2, 1, 0);
    run_op(1, 18, 0, 1'b0, 0, "ovl");
    chk("ovl_corner", get_out(1, 0), 32'd1);
    chk("ovl_center", get_out(1, 4), 32'd4);

    // cropped output
    ia = '{1, 1, 1, 1};
    wa = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    ba = '{0};
    drive(2);
    model(1, 1, 2, 2, 3, 1, 1);
    run_op(2, 38, 0, 1'b0, 0, "crop");
    chk("crop_e0", get_out(2, 0), 32'd4);
    chk("crop_e3", get_out(2, 3), 32'd4);

    // signed product
    ia = '{-3};
    wa = '{5};
    ba = '{0};
    drive(3);
    model(1, 1, 1, 1, 1, 1, 0);
    run_op(3, 3, 0, 1'b0, 0, "neg");
`ifdef CONVT_RELU_EN
    chk("neg_const", get_out(3, 0), 32'h0);
`else
    chk("neg_const", get_out(3, 0), 32'hFFFFFFF1);
`endif

    // truncated product wraps
    ia = '{32'h7FFFFFFF};
    wa = '{2};
    ba = '{0};
    drive(3);
    model(1, 1, 1, 1, 1, 1, 0);
    run_op(3, 3, 0, 1'b0, 0, "wrap");
`ifdef CONVT_RELU_EN
    chk("wrap_const", get_out(3, 0), 32'h0);
`else
    chk("wrap_const", get_out(3, 0), 32'hFFFFFFFE);
`endif

    chk("sb_leftover", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
